// File: rtl/motor_act_stream_if.sv
// Stream bundle for motor_act_stream: input sample handshake plus activated output handshake.
// The slave modport is the activation unit's side; master is the producer/consumer side.
interface motor_act_stream_if #(
  parameter int W = 21
) ();
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/motor_act_stream.sv
// Two-stage streaming activation (ReLU / leaky / clipped / pass) with per-vector mode latch.
// Optional saturation statistics via `define MOTOR_ACT_SAT_STATS_EN (adds sat_count port).
module motor_act_stream #(
  parameter int W          = 21,
  parameter int F          = 14,
  parameter int N_CH       = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_VAL   = 98304
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [1:0]         mode,
  motor_act_stream_if.slave  strm,
  output logic               busy
`ifdef MOTOR_ACT_SAT_STATS_EN
  , output logic [15:0]      sat_count
`endif
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0]       CH_LAST = CW'(N_CH - 1);
  localparam logic signed [W-1:0] CLIP_S  = W'(CLIP_VAL);
  localparam logic signed [W-1:0] ZERO_S  = '0;

  if (F < 0 || F >= W || N_CH < 1 || N_CH > 1024 || CLIP_VAL <= 0
      || CLIP_VAL >= 2 ** (W - 1) || LEAK_SHIFT < 0 || LEAK_SHIFT >= W) begin : g_bad_cfg
    $error("motor_act_stream: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_CLIP  = 2'd2,
    ACT_PASS  = 2'd3
  } act_mode_e;

  act_mode_e             mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  s1_valid_q, s1_valid_d;
  logic signed [W-1:0]   s1_data_q, s1_data_d;
  act_mode_e             s1_mode_q, s1_mode_d;
  logic                  s1_last_q, s1_last_d;

  logic                  s2_valid_q, s2_valid_d;
  logic signed [W-1:0]   s2_data_q, s2_data_d;
  logic                  s2_last_q, s2_last_d;

  logic                  in_ready_w;
  logic                  in_fire;
  logic                  out_fire;
  logic                  s2_free;
  logic                  s1_adv;
  act_mode_e             eff_mode;
  logic signed [W-1:0]   act_res;

  // Handshake: S2 empties on drain, S1 moves whenever S2 can take it.
  always_comb begin
    out_fire   = s2_valid_q && strm.out_ready;
    s2_free    = !s2_valid_q || strm.out_ready;
    s1_adv     = s1_valid_q && s2_free;
    in_ready_w = !s1_valid_q || s2_free;
    in_fire    = strm.in_valid && in_ready_w;
  end

  assign strm.in_ready  = in_ready_w;
  assign strm.out_valid = s2_valid_q;
  assign strm.out_data  = s2_data_q;
  assign strm.out_last  = s2_last_q;
  assign busy           = s1_valid_q || s2_valid_q;

  // The first beat of a vector uses the live mode input; later beats use the latched copy.
  always_comb begin
    eff_mode = (cnt_q == '0) ? act_mode_e'(mode) : mode_q;
  end

  always_comb begin
    act_res = s1_data_q;
    case (s1_mode_q)
      ACT_RELU: begin
        if (s1_data_q <= ZERO_S) act_res = '0;
      end
      ACT_LEAKY: begin
        if (s1_data_q < ZERO_S) act_res = s1_data_q >>> LEAK_SHIFT;
      end
      ACT_CLIP: begin
        if (s1_data_q <= ZERO_S)      act_res = '0;
        else if (s1_data_q > CLIP_S)  act_res = CLIP_S;
      end
      default: act_res = s1_data_q;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;

    if (in_fire) begin
      cnt_d      = (cnt_q == CH_LAST) ? '0 : cnt_q + CW'(1);
      mode_d     = eff_mode;
      s1_valid_d = 1'b1;
      s1_data_d  = $signed(strm.in_data);
      s1_mode_d  = eff_mode;
      s1_last_d  = (cnt_q == CH_LAST);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = act_res;
      s2_last_d  = s1_last_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      mode_q     <= ACT_RELU;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= ACT_RELU;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
    end
  end

`ifdef MOTOR_ACT_SAT_STATS_EN
  logic        act_sat;
  logic        s2_sat_q, s2_sat_d;
  logic [15:0] sat_q, sat_d;

  // Saturation event: clip ceiling exceeded, or a negative input forced to zero.
  always_comb begin
    act_sat = 1'b0;
    case (s1_mode_q)
      ACT_RELU: act_sat = (s1_data_q < ZERO_S);
      ACT_CLIP: act_sat = (s1_data_q < ZERO_S) || (s1_data_q > CLIP_S);
      default:  act_sat = 1'b0;
    endcase
  end

  always_comb begin
    s2_sat_d = s2_sat_q;
    sat_d    = sat_q;
    if (s1_adv) s2_sat_d = act_sat;
    if (out_fire && s2_sat_q && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s2_sat_q <= 1'b0;
      sat_q    <= '0;
    end else begin
      s2_sat_q <= s2_sat_d;
      sat_q    <= sat_d;
    end
  end

  assign sat_count = sat_q;
`endif

endmodule

// File: doc/motor_act_stream.md
# motor_act_stream

Parametrised, pipelined activation unit for the motor MLP datapath: accepts a stream of signed fixed-point neuron outputs, applies ReLU, leaky ReLU or clipped ReLU, and emits the result on a valid/ready stream. Sits between each dense layer and the next, replacing per-neuron combinational ReLU instances with one shared streaming block. It tracks channel position within a layer vector and flags the last element of each vector.

## Interface
- W, 21, total bits of input and output sample (signed, two's complement)
- F, 14, fractional bits (W-F integer bits incl. sign; default ap_fixed<21,7>)
- N_CH, 16, elements per layer vector (1..1024)
- LEAK_SHIFT, 3, negative-slope right shift for leaky mode (slope = 2^-LEAK_SHIFT)
- CLIP_VAL, 98304, clipped-ReLU ceiling in raw LSBs (6.0 at F=14); must be > 0 and < 2^(W-1)

- ap_clk  in  1  clock, all logic rising-edge
- ap_rst_n  in  1  synchronous, active-low reset
- mode  in  2  0 ReLU, 1 leaky ReLU, 2 clipped ReLU, 3 pass-through
- in_data  in  W  signed sample
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- out_data  out  W  activated sample (signed)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  out_data is channel N_CH-1 of its vector
- busy  out  1  any pipeline stage holds data

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Two register stages S1, S2. S1: capture sample, mode, channel tag, last flag. S2: compute activation, register result.
- Activation, x = sample:
  - ReLU: x > 0 ? x : 0 (x == 0 gives 0).
  - Leaky: x >= 0 ? x : x >>> LEAK_SHIFT (arithmetic shift, rounds toward -inf; -1 stays -1).
  - Clipped: x <= 0 ? 0 : (x > CLIP_VAL ? CLIP_VAL : x).
  - Pass-through: x unchanged.
- Mode latched into an internal register on the accepted beat with channel counter = 0; all remaining beats of that vector use the latched mode. mode changes mid-vector are ignored until the next vector.
- Channel counter: log2(N_CH)-wide, increments per accepted input beat, wraps N_CH-1 -> 0. Tag last = (counter == N_CH-1) travels with the sample to out_last.
- N_CH = 1: every beat is last; mode latched every beat.
- busy = S1 valid || S2 valid.

## Timing
- Reset (ap_rst_n low at a rising edge): out_valid=0, out_last=0, out_data=0, busy=0, channel counter=0, latched mode=0 (ReLU), both stage valids cleared; in_ready=1 from the first cycle after reset is released. Reset mid-vector discards in-flight data and restarts at channel 0.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high.
- Throughput: one sample per cycle with out_ready high.
- Backpressure: S2 holds when out_valid && !out_ready; S1 advances only when S2 empty or draining; in_ready = !S1 valid || S1 advancing. No combinational path in_valid -> out_valid; in_ready depends combinationally on out_ready.
- out_data/out_last stable while out_valid && !out_ready.
- Simultaneous accept and drain in one cycle: both occur, no bubble.

## Configuration
- MOTOR_ACT_SAT_STATS_EN defined: adds output sat_count (16 bits), count of output beats where clipped mode reached CLIP_VAL or ReLU/clipped zeroed a negative input; saturates at 0xFFFF; reset to 0; cleared on ap_rst_n only.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset: hold ap_rst_n low 3 cycles with in_valid=1 -> out_valid=0, busy=0, in_ready=1 cycle after release.
- ReLU, N_CH=4: inputs 16384, -16384, 0, 1 with out_ready=1 -> outputs 16384, 0, 0, 1 two cycles after each input; out_last only on 4th.
- Leaky: inputs -16384, -1, 8192 -> -2048, -1, 8192.
- Clipped: inputs 131072, 98304, -5 -> 98304, 98304, 0; sat_count = 2 with MOTOR_ACT_SAT_STATS_EN.
- Mode latch: switch mode 0->2 at channel 2 of a 4-channel vector -> remaining beats use ReLU; next vector uses clipped.
- Backpressure: out_ready low 5 cycles during continuous input -> in_ready drops after 2 accepted beats, out_data held stable, no loss or duplication when out_ready returns.
